// File: rtl/udp_frame_arbiter.sv
// Frame-granular round-robin read arbiter for NUM_SRC tagged byte ring buffers.
// Optional frame length reporting is enabled by defining UDP_ARB_LEN_EN.
module udp_frame_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int GNT_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_empty,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_first,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_rd_en,
    output logic [7:0]           out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GNT_W-1:0]     out_src,
    output logic                 err_sync
`ifdef UDP_ARB_LEN_EN
    ,
    output logic [15:0]          out_len,
    output logic                 out_len_valid
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_HOLD} state_t;

    state_t           r_state;
    logic [GNT_W-1:0] r_grant;
    logic [GNT_W-1:0] r_rr_last;
    logic             r_new_frame;
    logic [7:0]       r_out_data;
    logic             r_out_first;
    logic             r_out_last;
    logic             r_out_valid;
    logic             r_err_sync;

    logic             w_any;
    logic [GNT_W-1:0] w_pick;
    logic [GNT_W-1:0] w_idx;
    logic [7:0]       w_byte;

    // Search starts one past the last source that completed a frame.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            w_idx = GNT_W'((32'(r_rr_last) + i) % NUM_SRC);
            if (!w_any && !src_empty[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    // The strobe is decoded from state so the byte lands exactly in LATCH.
    always_comb begin
        src_rd_en = '0;
        if (r_state == S_FETCH && !src_empty[r_grant])
            src_rd_en[r_grant] = 1'b1;
    end

    assign w_byte = src_data[{r_grant, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_last   <= GNT_W'(NUM_SRC - 1);
            r_new_frame <= 1'b0;
            r_out_data  <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_sync  <= 1'b0;
        end else begin
            r_err_sync <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_new_frame <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!src_empty[r_grant])
                        r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_out_data  <= w_byte;
                    r_out_first <= src_first[r_grant] | r_new_frame;
                    r_out_last  <= src_last[r_grant];
                    r_out_valid <= 1'b1;
                    if (r_new_frame)
                        r_err_sync <= ~src_first[r_grant];
                    r_new_frame <= 1'b0;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_rr_last <= r_grant;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign out_src   = r_grant;
    assign err_sync  = r_err_sync;

`ifdef UDP_ARB_LEN_EN
    logic [15:0] r_len_cnt;
    logic [15:0] r_out_len;
    logic        r_len_valid;
    logic [15:0] w_len_next;

    assign w_len_next = (r_len_cnt == '1) ? r_len_cnt : r_len_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_cnt   <= '0;
            r_out_len   <= '0;
            r_len_valid <= 1'b0;
        end else begin
            r_len_valid <= 1'b0;
            if (r_state == S_IDLE && w_any) begin
                r_len_cnt <= '0;
            end else if (r_state == S_HOLD && out_ready) begin
                r_len_cnt <= w_len_next;
                if (r_out_last) begin
                    r_out_len   <= w_len_next;
                    r_len_valid <= 1'b1;
                end
            end
        end
    end

    assign out_len       = r_out_len;
    assign out_len_valid = r_len_valid;
`endif

endmodule

// File: tb/tb_udp_frame_arbiter.sv
// Bench for udp_frame_arbiter: queue-backed ring buffer models feed the DUT,
// a negedge monitor pops the expected-byte scoreboard on each output handshake.
module tb_udp_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src_empty = 2'b11;
    logic [15:0] src_data = '0;
    logic [1:0]  src_first = '0;
    logic [1:0]  src_last = '0;
    logic [1:0]  src_rd_en;
    logic [7:0]  out_data;
    logic        out_first;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  out_src;
    logic        err_sync;
`ifdef UDP_ARB_LEN_EN
    logic [15:0] out_len;
    logic        out_len_valid;
`endif

    always #5 clk = ~clk;

    udp_frame_arbiter #(.NUM_SRC(2), .GNT_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_empty (src_empty),
        .src_data  (src_data),
        .src_first (src_first),
        .src_last  (src_last),
        .src_rd_en (src_rd_en),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .err_sync  (err_sync)
`ifdef UDP_ARB_LEN_EN
        ,
        .out_len       (out_len),
        .out_len_valid (out_len_valid)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       e;
        logic       s;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_x;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] pop0;
    logic [9:0] pop1;
    int         n_chk = 0;
    int         n_pass = 0;
    int         strobe0 = 0;

    // Ring buffer models: one-cycle read latency, empty follows occupancy.
    always @(posedge clk) begin
        if (src_rd_en[0] && q0.size() > 0) begin
            pop0 = q0.pop_front();
            src_data[7:0] <= pop0[7:0];
            src_first[0]  <= pop0[8];
            src_last[0]   <= pop0[9];
        end
        if (src_rd_en[1] && q1.size() > 0) begin
            pop1 = q1.pop_front();
            src_data[15:8] <= pop1[7:0];
            src_first[1]   <= pop1[8];
            src_last[1]    <= pop1[9];
        end
        src_empty <= {q1.size() == 0, q0.size() == 0};
    end

    always @(negedge clk) begin
        if (src_rd_en != 2'b00) begin
            n_chk++;
            if ($countones(src_rd_en) == 1 && (src_rd_en & src_empty) == 2'b00) n_pass++;
            else $display("FAIL rd_en_legal: rd_en=%b empty=%b, required one-hot on a non-empty source",
                          src_rd_en, src_empty);
            if (src_rd_en[0]) strobe0++;
        end
        if (!rst && out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_byte: got data=%h src=%0d with empty scoreboard", out_data, out_src);
            end else begin
                mon_x = sb.pop_front();
                if ({out_data, out_first, out_last, err_sync, out_src} !==
                    {mon_x.d, mon_x.f, mon_x.l, mon_x.e, mon_x.s})
                    $display("FAIL byte: got d=%h f=%b l=%b err=%b src=%0d, required d=%h f=%b l=%b err=%b src=%0d",
                             out_data, out_first, out_last, err_sync, out_src,
                             mon_x.d, mon_x.f, mon_x.l, mon_x.e, mon_x.s);
                else n_pass++;
            end
        end
    end

    task automatic push_src(input int s, input logic [7:0] d, input logic f, input logic l);
        if (s == 0) q0.push_back({l, f, d});
        else        q1.push_back({l, f, d});
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic f, input logic l,
                               input logic e, input logic s);
        exp_t t;
        t.d = d; t.f = f; t.l = l; t.e = e; t.s = s;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_data, out_first, out_last, out_valid, out_src, err_sync, src_rd_en} !== '0)
            $display("FAIL reset_state: got d=%h f=%b l=%b v=%b src=%0d err=%b rd_en=%b, required all zero",
                     out_data, out_first, out_last, out_valid, out_src, err_sync, src_rd_en);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chk++;
            if (src_rd_en !== 2'b00 || out_valid !== 1'b0)
                $display("FAIL idle_empty: cycle %0d rd_en=%b valid=%b, required 00 and 0", c, src_rd_en, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_single_frame();
        int s_start;
        @(posedge clk); #1;
        s_start = strobe0;
        push_src(0, 8'hA1, 1'b1, 1'b0);
        push_src(0, 8'hA2, 1'b0, 1'b0);
        push_src(0, 8'hA3, 1'b0, 1'b1);
        expect_byte(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_byte(8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_byte(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL single_drain: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (strobe0 - s_start != 3) $display("FAIL single_strobes: got %0d rd_en[0] pulses, required 3", strobe0 - s_start);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_src(0, 8'hB0, 1'b1, 1'b0); push_src(0, 8'hB1, 1'b0, 1'b1);
        push_src(0, 8'hB2, 1'b1, 1'b0); push_src(0, 8'hB3, 1'b0, 1'b1);
        push_src(1, 8'hC0, 1'b1, 1'b0); push_src(1, 8'hC1, 1'b0, 1'b1);
        push_src(1, 8'hC2, 1'b1, 1'b0); push_src(1, 8'hC3, 1'b0, 1'b1);
        expect_byte(8'hB0, 1'b1, 1'b0, 1'b0, 1'b0); expect_byte(8'hB1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_byte(8'hC0, 1'b1, 1'b0, 1'b0, 1'b1); expect_byte(8'hC1, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_byte(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0); expect_byte(8'hB3, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_byte(8'hC2, 1'b1, 1'b0, 1'b0, 1'b1); expect_byte(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL rr_drain: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int c;
        @(posedge clk); #1;
        push_src(0, 8'hD0, 1'b1, 1'b0);
        push_src(0, 8'hD1, 1'b0, 1'b0);
        push_src(0, 8'hD2, 1'b0, 1'b1);
        expect_byte(8'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_byte(8'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_byte(8'hD2, 1'b0, 1'b1, 1'b0, 1'b0);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_first) break;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 8'hD1 || src_rd_en !== 2'b00)
                $display("FAIL bp_hold: cycle %0d valid=%b d=%h rd_en=%b, required 1 D1 00",
                         k, out_valid, out_data, src_rd_en);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL bp_drain: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_underrun();
        int c;
        @(posedge clk); #1;
        push_src(1, 8'hE1, 1'b1, 1'b0);
        push_src(0, 8'hF1, 1'b1, 1'b0);
        push_src(0, 8'hF2, 1'b0, 1'b1);
        expect_byte(8'hE1, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_byte(8'hE2, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_byte(8'hE3, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_byte(8'hF1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_byte(8'hF2, 1'b0, 1'b1, 1'b0, 1'b0);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_data == 8'hE1) break;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_chk++;
            if (src_rd_en !== 2'b00 || out_valid !== 1'b0)
                $display("FAIL underrun_stall: cycle %0d rd_en=%b valid=%b, required 00 and 0", k, src_rd_en, out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        push_src(1, 8'hE2, 1'b1, 1'b0);
        push_src(1, 8'hE3, 1'b0, 1'b1);
        for (c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL underrun_drain: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int c;
        @(posedge clk); #1;
        push_src(1, 8'h61, 1'b1, 1'b0);
        expect_byte(8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_byte(8'h62, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_byte(8'h63, 1'b0, 1'b1, 1'b0, 1'b1);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_data == 8'h61) break;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || out_src !== 1'b0 || src_rd_en !== 2'b00)
            $display("FAIL midframe_reset: valid=%b src=%0d rd_en=%b, required 0 0 00", out_valid, out_src, src_rd_en);
        else n_pass++;
        @(posedge clk); #1;
        push_src(1, 8'h62, 1'b0, 1'b0);
        push_src(1, 8'h63, 1'b0, 1'b1);
        for (c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL midframe_drain: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
    endtask

`ifdef UDP_ARB_LEN_EN
    task automatic test_len();
        int pulses;
        logic [15:0] got_len;
        pulses  = 0;
        got_len = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            push_src(0, 8'h70 + 8'(i), i == 0, i == 4);
            expect_byte(8'h70 + 8'(i), i == 0, i == 4, 1'b0, 1'b0);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_len_valid) begin
                pulses++;
                got_len = out_len;
            end
        end
        n_chk++;
        if (pulses != 1 || got_len !== 16'd5)
            $display("FAIL frame_len: got %0d pulses len=%0d, required 1 pulse len=5", pulses, got_len);
        else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_underrun();
        test_reset_midframe();
`ifdef UDP_ARB_LEN_EN
        test_len();
`endif
        repeat (4) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) $display("FAIL final_scoreboard: %0d bytes outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
